// File: rtl/seg7_pkg.sv
// Shared seven-segment constants for the ALU board display.
// Patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [7:0] AN_ALL_OFF = 8'hFF;

    // Hex digits 0-F; b and d are lowercase so they stay distinct from 8 and 0.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef logic [2:0] digit_idx_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment pattern decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_LUT[nibble];

endmodule

// File: rtl/an_scan_mux.sv
// Time-multiplexed driver for the 8-digit common-anode display.
// Lights one enabled digit per slot, skipping digits masked off by an_on.
// Optional feature: define AN_SCAN_GHOST_BLANK_EN to force the anodes off
// for the first BLANK_CYCLES cycles of every slot (anti-ghosting).
module an_scan_mux
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100_000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  an_on,
    input  logic [31:0] value,
    input  logic [7:0]  dp_on,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [2:0]  digit_idx
);

    localparam int unsigned PcntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

`ifdef AN_SCAN_GHOST_BLANK_EN
    localparam bit GhostBlank = 1'b1;
`else
    localparam bit GhostBlank = 1'b0;
`endif

    if (REFRESH_DIV < 2) begin : g_bad_div
        $error("an_scan_mux: REFRESH_DIV must be at least 2");
    end
    if (GhostBlank && (BLANK_CYCLES >= REFRESH_DIV)) begin : g_bad_blank
        $error("an_scan_mux: BLANK_CYCLES must be below REFRESH_DIV");
    end

    logic [PcntW-1:0] pcnt_q, pcnt_d;
    logic             tick;
    digit_idx_t       idx_q, idx_d;
    digit_idx_t       cand;
    logic             found;
    logic [3:0]       nibble;
    logic [6:0]       hex_seg;
    logic             lit;
    logic             blank;
    logic [7:0]       an_d, an_q;
    logic [6:0]       seg_d, seg_q;
    logic             dp_d, dp_q;

    // Prescaler: slot timing, wraps every REFRESH_DIV cycles.
    always_comb begin
        tick   = (pcnt_q == PcntW'(REFRESH_DIV - 1));
        pcnt_d = tick ? '0 : pcnt_q + PcntW'(1);
    end

    // Next enabled digit: rotate-search starting after the current index.
    // Offset 8 wraps onto the current digit, so a lone enabled digit holds;
    // an empty mask falls through to the plain +1 default.
    always_comb begin
        cand  = idx_q;
        found = 1'b0;
        idx_d = idx_q + 3'd1;
        for (int k = 1; k <= 8; k++) begin
            cand = idx_q + 3'(k);
            if (!found && an_on[cand]) begin
                idx_d = cand;
                found = 1'b1;
            end
        end
        if (!tick) begin
            idx_d = idx_q;
        end
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nibble),
        .seg    (hex_seg)
    );

`ifdef AN_SCAN_GHOST_BLANK_EN
    assign blank = (pcnt_q < PcntW'(BLANK_CYCLES));
`else
    assign blank = 1'b0;
`endif

    // Output drive for the current slot; dark when the digit is masked or blanked.
    always_comb begin
        nibble = value[{idx_q, 2'b00} +: 4];
        lit    = an_on[idx_q] && !blank;
        an_d   = AN_ALL_OFF;
        seg_d  = SEG_BLANK;
        dp_d   = 1'b1;
        if (lit) begin
            an_d  = ~(8'h01 << idx_q);
            seg_d = hex_seg;
            dp_d  = ~dp_on[idx_q];
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
            idx_q  <= '0;
            an_q   <= AN_ALL_OFF;
            seg_q  <= SEG_BLANK;
            dp_q   <= 1'b1;
        end else begin
            pcnt_q <= pcnt_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign digit_idx = idx_q;

endmodule

// File: tb/tb_an_scan_mux.sv
// Self-checking bench for an_scan_mux with REFRESH_DIV=4, BLANK_CYCLES=2.
module tb_an_scan_mux;

    localparam int unsigned RDIV  = 4;
    localparam int unsigned BLANK = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  an_on = 8'h00;
    logic [31:0] value = 32'h0;
    logic [7:0]  dp_on = 8'h00;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [2:0]  digit_idx;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [2:0] idx;
    } exp_t;

    exp_t sb[$];
    int         m_pcnt;
    logic [2:0] m_idx;

    an_scan_mux #(
        .REFRESH_DIV  (RDIV),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .an_on     (an_on),
        .value     (value),
        .dp_on     (dp_on),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .digit_idx (digit_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [2:0] ref_next(input logic [2:0] cur, input logic [7:0] m);
        logic [2:0] j;
        j = cur + 3'd1;
        if (m == 8'h00) return j;
        while (!m[j]) j = j + 3'd1;
        return j;
    endfunction

    function automatic bit in_blank(input int c);
`ifdef AN_SCAN_GHOST_BLANK_EN
        return (c % RDIV) < BLANK;
`else
        return (c < 0);
`endif
    endfunction

    // Model: compute the output the next edge should register, then advance.
    task automatic model_push();
        exp_t e;
        bit   blank;
`ifdef AN_SCAN_GHOST_BLANK_EN
        blank = (m_pcnt < BLANK);
`else
        blank = 1'b0;
`endif
        if (an_on[m_idx] && !blank) begin
            e.an  = 8'hFF ^ (8'h01 << m_idx);
            e.seg = ref_seg(value[m_idx*4 +: 4]);
            e.dp  = ~dp_on[m_idx];
        end else begin
            e.an  = 8'hFF;
            e.seg = 7'h7F;
            e.dp  = 1'b1;
        end
        if (m_pcnt == RDIV - 1) begin
            m_pcnt = 0;
            m_idx  = ref_next(m_idx, an_on);
        end else begin
            m_pcnt = m_pcnt + 1;
        end
        e.idx = m_idx;
        sb.push_back(e);
    endtask

    // One clock: push expectation, clock, pop and compare at the falling edge.
    task automatic step();
        exp_t e;
        model_push();
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: got empty queue, required an entry");
            return;
        end
        e = sb.pop_front();
        if (an !== e.an) begin
            errors++;
            $display("FAIL sb_an: got %h required %h at %0t", an, e.an, $time);
        end
        checks++;
        if (seg !== e.seg) begin
            errors++;
            $display("FAIL sb_seg: got %h required %h at %0t", seg, e.seg, $time);
        end
        checks++;
        if (dp !== e.dp) begin
            errors++;
            $display("FAIL sb_dp: got %b required %b at %0t", dp, e.dp, $time);
        end
        checks++;
        if (digit_idx !== e.idx) begin
            errors++;
            $display("FAIL sb_idx: got %0d required %0d at %0t", digit_idx, e.idx, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n  = 1'b1;
        m_pcnt = 0;
        m_idx  = 3'd0;
        sb.delete();
    endtask

    task automatic test_reset();
        #2;
        an_on = $urandom;
        value = $urandom;
        dp_on = $urandom;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || digit_idx !== 3'd0) begin
                errors++;
                $display("FAIL reset_hold: got an=%h seg=%h dp=%b idx=%0d required FF 7F 1 0",
                         an, seg, dp, digit_idx);
            end
            @(negedge clk);
            an_on = $urandom;
            value = $urandom;
        end
        rst_n  = 1'b1;
        m_pcnt = 0;
        m_idx  = 3'd0;
        sb.delete();
    endtask

    task automatic test_full_scan();
        logic [2:0] d;
        logic [7:0] exp_an;
        do_reset();
        an_on = 8'hFF;
        value = 32'h7654_3210;
        dp_on = 8'h00;
        for (int c = 0; c < 36; c++) begin
            step();
            d      = 3'((c / 4) % 8);
            exp_an = in_blank(c) ? 8'hFF : (8'hFF ^ (8'h01 << d));
            checks++;
            if (an !== exp_an) begin
                errors++;
                $display("FAIL scan_an: got %h required %h (cycle %0d)", an, exp_an, c);
            end
            if (!in_blank(c)) begin
                checks++;
                if (seg !== ref_seg({1'b0, d})) begin
                    errors++;
                    $display("FAIL scan_seg: got %h required %h (cycle %0d)",
                             seg, ref_seg({1'b0, d}), c);
                end
            end
        end
    endtask

    task automatic test_skip();
        logic [2:0] seq [5];
        seq[0] = 3'd0; seq[1] = 3'd1; seq[2] = 3'd6; seq[3] = 3'd7; seq[4] = 3'd0;
        do_reset();
        an_on = 8'b1100_0011;
        value = 32'hFEDC_BA98;
        for (int c = 0; c < 20; c++) begin
            step();
            checks++;
            if (an[5:2] !== 4'hF) begin
                errors++;
                $display("FAIL skip_an: got %h required bits 5..2 high", an);
            end
            if (c % 4 == 0) begin
                checks++;
                if (digit_idx !== seq[c / 4]) begin
                    errors++;
                    $display("FAIL skip_idx: got %0d required %0d", digit_idx, seq[c / 4]);
                end
            end
        end
    endtask

    task automatic test_single_and_empty();
        do_reset();
        an_on = 8'h04;
        value = $urandom;
        for (int c = 0; c < 24; c++) begin
            step();
            if (c >= 4) begin
                checks++;
                if (digit_idx !== 3'd2 || an !== (in_blank(c) ? 8'hFF : 8'hFB)) begin
                    errors++;
                    $display("FAIL single: got idx=%0d an=%h required idx=2 an=%h",
                             digit_idx, an, in_blank(c) ? 8'hFF : 8'hFB);
                end
            end
        end
        do_reset();
        an_on = 8'h00;
        for (int c = 0; c < 16; c++) begin
            value = $urandom;
            step();
            checks++;
            if (an !== 8'hFF || seg !== 7'h7F) begin
                errors++;
                $display("FAIL empty: got an=%h seg=%h required FF 7F", an, seg);
            end
        end
    endtask

    task automatic test_mid_change();
        int n;
        do_reset();
        an_on = 8'h07;
        value = 32'h0000_0A5C;
        n = 0;
        while (digit_idx !== 3'd2 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (digit_idx !== 3'd2) begin
            errors++;
            $display("FAIL mid_reach: got idx=%0d required 2", digit_idx);
        end
        step();
        an_on = 8'h03;
        step();
        checks++;
        if (an !== 8'hFF) begin
            errors++;
            $display("FAIL mid_dark: got an=%h required FF", an);
        end
        n = 0;
        while (digit_idx === 3'd2 && n < 8) begin
            step();
            n++;
        end
        checks++;
        if (digit_idx !== 3'd0) begin
            errors++;
            $display("FAIL mid_next: got idx=%0d required 0", digit_idx);
        end
    endtask

    task automatic test_dp();
        logic exp_dp;
        do_reset();
        an_on = 8'hFF;
        dp_on = 8'h01;
        value = $urandom;
        for (int c = 0; c < 32; c++) begin
            step();
            exp_dp = !(((c / 4) % 8 == 0) && !in_blank(c));
            checks++;
            if (dp !== exp_dp) begin
                errors++;
                $display("FAIL dp: got %b required %b (cycle %0d)", dp, exp_dp, c);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 200; c++) begin
            if (c % 3 == 0) an_on = $urandom;
            value = $urandom;
            dp_on = $urandom;
            step();
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        an_on = 8'hFF;
        value = 32'h1234_5678;
        for (int c = 0; c < 6; c++) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || digit_idx !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset: got an=%h seg=%h dp=%b idx=%0d required FF 7F 1 0",
                     an, seg, dp, digit_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_skip();
        test_single_and_empty();
        test_mid_change();
        test_dp();
        test_random();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
